// File: rtl/terminal_text_buffer_if.sv
// Character-input handshake, renderer read port and cursor outputs of terminal_text_buffer.
interface terminal_text_buffer_if #(
   parameter int unsigned COLS = 80,
   parameter int unsigned ROWS = 30
);
   localparam int unsigned COL_W = $clog2(COLS);
   localparam int unsigned ROW_W = $clog2(ROWS);

   logic [7:0]       ascii_code;
   logic             ascii_valid;
   logic             ascii_ready;
   logic [ROW_W-1:0] rd_row;
   logic [COL_W-1:0] rd_col;
   logic [7:0]       rd_char;
   logic [ROW_W-1:0] cursor_row;
   logic [COL_W-1:0] cursor_col;

   modport master (
      output ascii_code, ascii_valid, rd_row, rd_col,
      input  ascii_ready, rd_char, cursor_row, cursor_col
   );

   modport slave (
      input  ascii_code, ascii_valid, rd_row, rd_col,
      output ascii_ready, rd_char, cursor_row, cursor_col
   );
endinterface

// File: rtl/terminal_text_buffer.sv
// Character-cell text store with cursor, control-code handling and top-row-pointer scrolling.
// Optional feature: define TERM_TAB_EN to expand 0x09 to spaces up to the next 8-column stop.
module terminal_text_buffer #(
   parameter int unsigned COLS = 80,
   parameter int unsigned ROWS = 30
) (
   input logic clock,
   input logic reset,
   terminal_text_buffer_if.slave bus
);
   localparam int unsigned COL_W  = $clog2(COLS);
   localparam int unsigned ROW_W  = $clog2(ROWS);
   localparam int unsigned RS_W   = ROW_W + 1;
   localparam int unsigned CS_W   = COL_W + 1;
   localparam int unsigned CELLS  = ROWS * COLS;
   localparam int unsigned ADDR_W = $clog2(CELLS);

   localparam logic [7:0]        SPACE     = 8'h20;
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
   localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(CELLS - 1);

   typedef enum logic [2:0] {
      INIT_CLEAR,
      IDLE,
      SCROLL_CLEAR,
      PAGE_CLEAR
`ifdef TERM_TAB_EN
      , TAB_FILL
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  top_q, top_d;
   logic [ADDR_W-1:0] clr_q, clr_d;
   logic              ready_q, ready_d;
   logic [7:0]        rd_char_q;

   logic [7:0]        mem_q [CELLS];

   logic              we_c;
   logic [ADDR_W-1:0] waddr_c;
   logic [7:0]        wdata_c;
   logic              newline_c;
   logic [ADDR_W-1:0] cur_addr_c;
   logic              rd_ok_c;
   logic [ADDR_W-1:0] raddr_c;

   // Logical (row, col) to flat RAM address, rotating rows by the top pointer.
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] top,
                                                   input logic [ROW_W-1:0] lrow,
                                                   input logic [COL_W-1:0] col);
      logic [RS_W-1:0] sum;
      sum = {1'b0, top} + {1'b0, lrow};
      if (sum >= RS_W'(ROWS)) sum = sum - RS_W'(ROWS);
      return ADDR_W'(sum) * ADDR_W'(COLS) + ADDR_W'(col);
   endfunction

   assign cur_addr_c = cell_addr(top_q, row_q, col_q);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= INIT_CLEAR;
         row_q   <= '0;
         col_q   <= '0;
         top_q   <= '0;
         clr_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         top_q   <= top_d;
         clr_q   <= clr_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      top_d     = top_q;
      clr_d     = clr_q;
      we_c      = 1'b0;
      waddr_c   = cur_addr_c;
      wdata_c   = SPACE;
      newline_c = 1'b0;

      case (state_q)
         INIT_CLEAR, PAGE_CLEAR: begin
            we_c    = 1'b1;
            waddr_c = clr_q;
            if (clr_q == CELL_LAST) begin
               state_d = IDLE;
               clr_d   = '0;
            end else begin
               clr_d = clr_q + ADDR_W'(1);
            end
         end

         SCROLL_CLEAR: begin
            we_c    = 1'b1;
            waddr_c = cell_addr(top_q, ROW_LAST, clr_q[COL_W-1:0]);
            if (clr_q[COL_W-1:0] == COL_LAST) begin
               state_d = IDLE;
               clr_d   = '0;
            end else begin
               clr_d = clr_q + ADDR_W'(1);
            end
         end

         IDLE: begin
            if (bus.ascii_valid) begin
               if (bus.ascii_code >= 8'h20 && bus.ascii_code <= 8'h7E) begin
                  we_c    = 1'b1;
                  wdata_c = bus.ascii_code;
                  if (col_q == COL_LAST) begin
                     col_d     = '0;
                     newline_c = 1'b1;
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end else begin
                  case (bus.ascii_code)
                     8'h0A, 8'h0D: begin
                        col_d     = '0;
                        newline_c = 1'b1;
                     end
                     8'h08: begin
                        if (row_q != '0 || col_q != '0) begin
                           we_c = 1'b1;
                           if (col_q == '0) begin
                              row_d   = row_q - ROW_W'(1);
                              col_d   = COL_LAST;
                              waddr_c = cell_addr(top_q, row_q - ROW_W'(1), COL_LAST);
                           end else begin
                              col_d   = col_q - COL_W'(1);
                              waddr_c = cell_addr(top_q, row_q, col_q - COL_W'(1));
                           end
                        end
                     end
                     8'h0C: begin
                        state_d = PAGE_CLEAR;
                        row_d   = '0;
                        col_d   = '0;
                        top_d   = '0;
                        clr_d   = '0;
                     end
`ifdef TERM_TAB_EN
                     8'h09: state_d = TAB_FILL;
`endif
                     default: ;
                  endcase
               end
            end
         end

`ifdef TERM_TAB_EN
         // One space per cycle until the column reaches a multiple of 8 or the row ends.
         TAB_FILL: begin
            we_c = 1'b1;
            if (col_q == COL_LAST) begin
               col_d     = '0;
               newline_c = 1'b1;
               state_d   = IDLE;
            end else begin
               col_d = col_q + COL_W'(1);
               if (col_q[2:0] == 3'd7) state_d = IDLE;
            end
         end
`endif

         default: state_d = INIT_CLEAR;
      endcase

      // Row advance; on the last row rotate the screen instead and clear the new bottom row.
      if (newline_c) begin
         if (row_q == ROW_LAST) begin
            top_d   = (top_q == ROW_LAST) ? '0 : top_q + ROW_W'(1);
            state_d = SCROLL_CLEAR;
            clr_d   = '0;
         end else begin
            row_d = row_q + ROW_W'(1);
         end
      end

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clock) begin
      if (we_c) mem_q[waddr_c] <= wdata_c;
   end

   assign rd_ok_c = ({1'b0, bus.rd_row} < RS_W'(ROWS)) && ({1'b0, bus.rd_col} < CS_W'(COLS));
   assign raddr_c = rd_ok_c ? cell_addr(top_q, bus.rd_row, bus.rd_col) : '0;

   // Registered read; a same-edge write to the same cell returns the old contents.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) rd_char_q <= SPACE;
      else       rd_char_q <= rd_ok_c ? mem_q[raddr_c] : SPACE;
   end

   assign bus.ascii_ready = ready_q;
   assign bus.rd_char     = rd_char_q;
   assign bus.cursor_row  = row_q;
   assign bus.cursor_col  = col_q;
endmodule

// File: tb/tb_terminal_text_buffer.sv
// Directed, table-driven bench for terminal_text_buffer (default build; tab checks follow TERM_TAB_EN).
module tb_terminal_text_buffer;
   localparam int unsigned COLS  = 80;
   localparam int unsigned ROWS  = 30;
   localparam int unsigned COL_W = $clog2(COLS);
   localparam int unsigned ROW_W = $clog2(ROWS);
   localparam int LIMIT = 5000;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   terminal_text_buffer_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

   terminal_text_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [7:0] code;
      int         exp_row;
      int         exp_col;
      int         chk_row;
      int         chk_col;
      logic [7:0] exp_char;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [7:0] c);
      int n;
      n = 0;
      bus.ascii_code  = c;
      bus.ascii_valid = 1'b1;
      while (!bus.ascii_ready && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) check("send_timeout", 32'(n), 32'(0));
      @(negedge clk);
      bus.ascii_valid = 1'b0;
   endtask

   task automatic busy_count(output int n);
      n = 0;
      while (!bus.ascii_ready && n < LIMIT) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic read_cell(input int r, input int c, output logic [7:0] v);
      bus.rd_row = ROW_W'(r);
      bus.rd_col = COL_W'(c);
      @(negedge clk);
      v = bus.rd_char;
   endtask

   task automatic check_cursor(input string name, input int r, input int c);
      check({name, "_row"}, 32'(bus.cursor_row), 32'(r));
      check({name, "_col"}, 32'(bus.cursor_col), 32'(c));
   endtask

   // Counts cells differing from the expected screen: row a_row all 'A', the rest spaces.
   task automatic scan(input int a_row, output int bad);
      logic [7:0] v;
      bad = 0;
      for (int r = 0; r < int'(ROWS); r++) begin
         for (int c = 0; c < int'(COLS); c++) begin
            read_cell(r, c, v);
            if (v !== ((r == a_row) ? 8'h41 : 8'h20)) bad++;
         end
      end
   endtask

   task automatic page_clear();
      int n;
      send(8'h0C);
      busy_count(n);
      check("page_clear_busy", 32'(n), 32'(2400));
   endtask

   initial begin
      int n;
      int bad;
      int t0;
      logic [7:0] v;

      vecs[0]  = '{8'h08, 0, 0,  0, 0,  8'h20};
      vecs[1]  = '{8'h48, 0, 1,  0, 0,  8'h48};
      vecs[2]  = '{8'h69, 0, 2,  0, 1,  8'h69};
      vecs[3]  = '{8'h08, 0, 1,  0, 1,  8'h20};
      vecs[4]  = '{8'h0D, 1, 0,  0, 0,  8'h48};
      vecs[5]  = '{8'h08, 0, 79, 0, 79, 8'h20};
      vecs[6]  = '{8'h78, 1, 0,  0, 79, 8'h78};
      vecs[7]  = '{8'h0A, 2, 0,  1, 0,  8'h20};
      vecs[8]  = '{8'h07, 2, 0,  0, 0,  8'h48};
      vecs[9]  = '{8'h7F, 2, 0,  2, 0,  8'h20};
      vecs[10] = '{8'h7E, 2, 1,  2, 0,  8'h7E};
      vecs[11] = '{8'h20, 2, 2,  2, 1,  8'h20};
      vecs[12] = '{8'h1F, 2, 2,  0, 1,  8'h20};
      vecs[13] = '{8'h08, 2, 1,  2, 1,  8'h20};

      rst             = 1'b1;
      bus.ascii_code  = 8'h00;
      bus.ascii_valid = 1'b0;
      bus.rd_row      = '0;
      bus.rd_col      = '0;
      #1;
      check("reset_ready", 32'(bus.ascii_ready), 32'(0));
      check("reset_rd_char", 32'(bus.rd_char), 32'h20);
      check_cursor("reset_cursor", 0, 0);

      repeat (3) @(negedge clk);
      rst = 1'b0;
      busy_count(n);
      check("init_busy", 32'(n), 32'(2400));
      check_cursor("init_cursor", 0, 0);
      read_cell(0, 0, v);
      check("init_cell_0_0", 32'(v), 32'h20);
      read_cell(29, 79, v);
      check("init_cell_29_79", 32'(v), 32'h20);

      foreach (vecs[i]) begin
         send(vecs[i].code);
         check(  $sformatf("vec%0d_ready", i), 32'(bus.ascii_ready), 32'(1));
         check_cursor($sformatf("vec%0d_cursor", i), vecs[i].exp_row, vecs[i].exp_col);
         read_cell(vecs[i].chk_row, vecs[i].chk_col, v);
         check($sformatf("vec%0d_cell", i), 32'(v), 32'(vecs[i].exp_char));
      end

      read_cell(30, 0, v);
      check("oob_row30", 32'(v), 32'h20);
      read_cell(31, 0, v);
      check("oob_row31", 32'(v), 32'h20);
      read_cell(0, 80, v);
      check("oob_col80", 32'(v), 32'h20);

      // Read and write of the cursor cell on the same edge.
      bus.rd_row      = ROW_W'(2);
      bus.rd_col      = COL_W'(1);
      bus.ascii_code  = 8'h57;
      bus.ascii_valid = 1'b1;
      @(negedge clk);
      bus.ascii_valid = 1'b0;
      check("rbw_old", 32'(bus.rd_char), 32'h20);
      @(negedge clk);
      check("rbw_new", 32'(bus.rd_char), 32'h57);
      check_cursor("rbw_cursor", 2, 2);

      page_clear();
      check_cursor("page_cursor", 0, 0);
      scan(-1, bad);
      check("page_scan_bad", 32'(bad), 32'(0));

      // Code held valid throughout the page clear must be taken only once ready returns.
      send(8'h51);
      send(8'h0C);
      bus.ascii_code  = 8'h5A;
      bus.ascii_valid = 1'b1;
      busy_count(n);
      check("held_busy", 32'(n), 32'(2400));
      @(negedge clk);
      bus.ascii_valid = 1'b0;
      check_cursor("held_cursor", 0, 1);
      read_cell(0, 0, v);
      check("held_cell", 32'(v), 32'h5A);

      page_clear();
      for (int i = 0; i < 83; i++) send(8'h58);
      check_cursor("x83_cursor", 1, 3);
      send(8'h09);
      busy_count(n);
`ifdef TERM_TAB_EN
      check("tab_busy", 32'(n), 32'(5));
      check_cursor("tab_cursor", 1, 8);
`else
      check("tab_busy", 32'(n), 32'(0));
      check_cursor("tab_cursor", 1, 3);
`endif
      read_cell(1, 2, v);
      check("tab_cell_1_2", 32'(v), 32'h58);
      read_cell(1, 5, v);
      check("tab_cell_1_5", 32'(v), 32'h20);

      page_clear();
      send(8'h4D);
      for (int i = 0; i < 29; i++) send(8'h0A);
      check_cursor("nl29_cursor", 29, 0);
      t0 = cyc;
      for (int i = 0; i < 80; i++) send(8'h41);
      check("a_stream_cycles", 32'(cyc - t0), 32'(80));
      busy_count(n);
      check("scroll_busy", 32'(n), 32'(80));
      check_cursor("scroll_cursor", 29, 0);
      read_cell(28, 0, v);
      check("scroll_cell_28_0", 32'(v), 32'h41);
      read_cell(29, 79, v);
      check("scroll_cell_29_79", 32'(v), 32'h20);
      scan(28, bad);
      check("scroll_scan_bad", 32'(bad), 32'(0));

      page_clear();
      send(8'h0A);
      send(8'h4B);
      for (int i = 0; i < 28; i++) send(8'h0A);
      check_cursor("pre_scroll_cursor", 29, 0);
      send(8'h0A);
      read_cell(0, 0, v);
      check("mid_scroll_cell", 32'(v), 32'h4B);
      check("mid_scroll_ready", 32'(bus.ascii_ready), 32'(0));
      check_cursor("mid_scroll_cursor", 29, 0);
      #2 rst = 1'b1;
      #1;
      check("async_reset_ready", 32'(bus.ascii_ready), 32'(0));
      check("async_reset_rd_char", 32'(bus.rd_char), 32'h20);
      check_cursor("async_reset_cursor", 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      busy_count(n);
      check("reinit_busy", 32'(n), 32'(2400));
      read_cell(0, 0, v);
      check("reinit_cell", 32'(v), 32'h20);
      check_cursor("reinit_cursor", 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/terminal_text_buffer.md
# terminal_text_buffer

Character-cell text store feeding the terminal renderer of the VGA typer path. Accepts a stream of ASCII codes from the keyboard/decoder side through a valid/ready handshake, writes printable characters at a cursor, and interprets backspace, newline, form-feed and (optionally) tab. Scrolling is done by rotating a top-row pointer and clearing the new bottom row. A registered read port lets the renderer fetch any on-screen cell by logical row/column.

## Interface
- COLS, 80, characters per row (640 px / 8 px glyph)
- ROWS, 30, rows per screen (480 px / 16 px glyph)
- COL_W, $clog2(COLS), derived column index width
- ROW_W, $clog2(ROWS), derived row index width

- clock  in  1  single clock for all state; all flops rise on posedge clock
- reset  in  1  asynchronous, active-high; clears all control state
- ascii_code  in  8  incoming character code
- ascii_valid  in  1  ascii_code is valid this cycle
- ascii_ready  out  1  block can accept a code this cycle
- rd_row  in  ROW_W  logical row to read (0 = top of screen)
- rd_col  in  COL_W  column to read
- rd_char  out  8  cell contents, registered
- cursor_row  out  ROW_W  logical cursor row
- cursor_col  out  COL_W  cursor column

## Operation
- Storage: ROWS×COLS×8 RAM, physical row = (top + logical row) mod ROWS; top wraps ROWS-1→0.
- States: INIT_CLEAR, IDLE, SCROLL_CLEAR, PAGE_CLEAR, TAB_FILL (TAB_FILL only with TERM_TAB_EN).
- Transfer occurs when ascii_valid && ascii_ready on a rising edge; ascii_ready = 1 only in IDLE.
- 0x20–0x7E: write code at cursor, col+1. At col COLS-1: col→0, row+1. If row was ROWS-1: top+1, row stays ROWS-1, enter SCROLL_CLEAR.
- 0x0A or 0x0D: col→0, row+1; same scroll rule at row ROWS-1.
- 0x08: at (0,0) no-op; at col 0 move to (row-1, COLS-1); else col-1; write 0x20 at new position.
- 0x0C: enter PAGE_CLEAR; cursor→(0,0), top→0.
- All other codes: accepted, no effect.
- SCROLL_CLEAR: write 0x20 to new bottom physical row, col 0..COLS-1, one cell/cycle, then IDLE.
- PAGE_CLEAR / INIT_CLEAR: write 0x20 to all ROWS×COLS cells, one/cycle, then IDLE.
- Read port: rd_char ← RAM[(top+rd_row) mod ROWS][rd_col] each cycle; same-cycle write to same cell returns old contents (read-before-write). rd_row ≥ ROWS or rd_col ≥ COLS returns 0x20.

## Timing
- Reset values: ascii_ready 0, cursor_row 0, cursor_col 0, rd_char 0x20, top 0, state INIT_CLEAR. RAM contents not reset; INIT_CLEAR overwrites them.
- Reset asserted mid-operation (any state): abort immediately; on release restart INIT_CLEAR from cell 0.
- INIT_CLEAR / PAGE_CLEAR: exactly ROWS×COLS cycles of writes; ascii_ready rises the cycle after the last write (2400 cycles at defaults).
- SCROLL_CLEAR: exactly COLS cycles; ascii_ready 0 throughout.
- Printable/backspace/newline: handled in the accept cycle; ascii_ready stays 1, one code per cycle sustainable.
- Cursor outputs update on the accepting edge; visible the following cycle.
- rd_char latency: 1 cycle from rd_row/rd_col; top change takes effect for addresses sampled on the next edge.
- Index arithmetic: row/col/top counters saturate or wrap only as stated; no value ≥ ROWS/COLS ever stored.

## Configuration
- TERM_TAB_EN defined: 0x09 enters TAB_FILL, writes 0x20 from cursor up to next column multiple of 8 (one cell/cycle, ascii_ready 0), then IDLE; if that reaches COLS, wraps as newline (with scroll rule). Tab at col 79 writes one space then wraps.
- TERM_TAB_EN undefined: 0x09 treated as an ignored code; TAB_FILL state absent.

## Test plan
- Reset release → ascii_ready 0 for 2400 cycles, then 1; read (0,0) and (29,79) → 0x20; cursor (0,0).
- Send 'H','i' back-to-back → (0,0)=0x48, (0,1)=0x69, cursor (0,2); then 0x08 → (0,1)=0x20, cursor (0,1).
- Fill row 29 after 29 newlines with 80 × 'A' → ascii_ready low exactly 80 cycles, old row 0 contents appear nowhere, logical row 28 = all 'A', row 29 = all 0x20, cursor (29,0).
- Send 0x0C mid-screen → 2400 busy cycles, all cells 0x20, cursor (0,0); ascii_valid held high during busy is not accepted until ready.
- With TERM_TAB_EN: cursor col 3, send 0x09 → cols 3..7 = 0x20, cursor col 8, ready low 5 cycles; without: cursor unchanged.
- Assert reset during SCROLL_CLEAR → outputs return to reset values asynchronously; INIT_CLEAR restarts on release.
